// File: rtl/mnist_bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mnist_bnn_pkg
// Purpose : Shared top-level state encodings and load-vector geometry.
// Revision: 1.0 - initial release
// ============================================================================
package mnist_bnn_pkg;

   localparam int BYTE_W    = 8;
   localparam int PIX_BITS  = 784;
   localparam int WT_BITS   = 72;

   function automatic int bytes_of(input int bits);
      return bits / BYTE_W;
   endfunction

   localparam int PIX_BYTES  = bytes_of(PIX_BITS);
   localparam int WT_BYTES   = bytes_of(WT_BITS);
   localparam int LOAD_BYTES = PIX_BYTES + WT_BYTES;

   typedef logic [2:0] top_state_t;

   localparam top_state_t S_IDLE    = 3'b000;
   localparam top_state_t S_LOAD    = 3'b001;
   localparam top_state_t S_LAYER_1 = 3'b010;

endpackage : mnist_bnn_pkg
`default_nettype wire

// File: rtl/input_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : input_loader_if
// Purpose : Host byte bus (data + async strobe) and the assembled load vectors.
// Revision: 1.0 - initial release
// ============================================================================
interface input_loader_if
   import mnist_bnn_pkg::*;
#(
   parameter int PIX_BITS = mnist_bnn_pkg::PIX_BITS,
   parameter int WT_BITS  = mnist_bnn_pkg::WT_BITS,
   parameter int BYTE_W   = mnist_bnn_pkg::BYTE_W
);

   logic [BYTE_W-1:0]   data_in;
   logic                strobe;
   logic [PIX_BITS-1:0] pixels;
   logic [WT_BITS-1:0]  weights;
   logic [6:0]          byte_cnt;
   logic                done;

   modport master (
      output data_in,
      output strobe,
      input  pixels,
      input  weights,
      input  byte_cnt,
      input  done
   );

   modport slave (
      input  data_in,
      input  strobe,
      output pixels,
      output weights,
      output byte_cnt,
      output done
   );

endinterface : input_loader_if
`default_nettype wire

// File: rtl/input_loader_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_detect
// Purpose : Two-flop synchroniser for an asynchronous pin plus a one-clock
//           rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module sync_edge_detect (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_pin,
   output logic      o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_sync3;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/input_loader.sv
`default_nettype none
// ============================================================================
// Module  : input_loader
// Purpose : Assembles the strobed host byte stream into the layer-1 image and
//           kernel vectors, then raises done.
// Revision: 1.0 - initial release
// ============================================================================
module input_loader
   import mnist_bnn_pkg::*;
#(
   parameter int PIX_BITS = mnist_bnn_pkg::PIX_BITS,
   parameter int WT_BITS  = mnist_bnn_pkg::WT_BITS,
   parameter int BYTE_W   = mnist_bnn_pkg::BYTE_W
)(
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic [2:0] state,
   input_loader_if.slave   bus
);

   localparam int N_PIX_BYTES = PIX_BITS / BYTE_W;
   localparam int N_WT_BYTES  = WT_BITS / BYTE_W;
   localparam int N_BYTES     = N_PIX_BYTES + N_WT_BYTES;

   localparam logic [1:0] P_PIX  = 2'd0;
   localparam logic [1:0] P_WT   = 2'd1;
   localparam logic [1:0] P_DONE = 2'd2;

   logic                   w_strobe_rise;
   logic                   w_accept;
   logic [N_PIX_BYTES-1:0] w_pix_we;
   logic [N_WT_BYTES-1:0]  w_wt_we;

   logic [1:0]             r_phase;
   logic [6:0]             r_byte_cnt;
   logic                   r_done;
   logic [PIX_BITS-1:0]    r_pixels;
   logic [WT_BITS-1:0]     r_weights;

   // Synchroniser runs in every top-level state so a strobe already high on
   // entry to S_LOAD never looks like a fresh edge.
   sync_edge_detect u_strobe_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_pin  (bus.strobe),
      .o_rise (w_strobe_rise)
   );

   assign w_accept = w_strobe_rise && (state == S_LOAD) && (r_phase != P_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= P_PIX;
         r_byte_cnt <= 7'd0;
         r_done     <= 1'b0;
      end else if (w_accept) begin
         if (r_byte_cnt != 7'(N_BYTES)) begin
            r_byte_cnt <= r_byte_cnt + 7'd1;
         end
         case (r_phase)
            P_PIX: begin
               if (r_byte_cnt == 7'(N_PIX_BYTES - 1)) begin
                  r_phase <= P_WT;
               end
            end
            P_WT: begin
               if (r_byte_cnt == 7'(N_BYTES - 1)) begin
                  r_phase <= P_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_phase <= P_DONE;
            end
         endcase
      end
   end

   // Per-byte write enables decoded from the running byte index.
   generate
      for (genvar gi = 0; gi < N_PIX_BYTES; gi++) begin : g_pix_we
         assign w_pix_we[gi] = w_accept && (r_phase == P_PIX) &&
                               (r_byte_cnt == 7'(gi));
      end
      for (genvar gj = 0; gj < N_WT_BYTES; gj++) begin : g_wt_we
         assign w_wt_we[gj] = w_accept && (r_phase == P_WT) &&
                              (r_byte_cnt == 7'(N_PIX_BYTES + gj));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pixels <= '0;
      end else begin
         for (int i = 0; i < N_PIX_BYTES; i++) begin
            if (w_pix_we[i]) begin
               r_pixels[i*BYTE_W +: BYTE_W] <= bus.data_in;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_weights <= '0;
      end else begin
         for (int j = 0; j < N_WT_BYTES; j++) begin
            if (w_wt_we[j]) begin
               r_weights[j*BYTE_W +: BYTE_W] <= bus.data_in;
            end
         end
      end
   end

   assign bus.pixels   = r_pixels;
   assign bus.weights  = r_weights;
   assign bus.byte_cnt = r_byte_cnt;
   assign bus.done     = r_done;

endmodule : input_loader
`default_nettype wire

// File: tb/tb_input_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_loader
// Purpose : Directed self-checking bench for input_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_input_loader;
   import mnist_bnn_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] state;

   int n_pass  = 0;
   int n_total = 0;

   logic [PIX_BITS-1:0] exp_pix;
   logic [WT_BITS-1:0]  exp_wt;

   input_loader_if bus ();

   input_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .state (state),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One host byte: strobe high 3 clk, low 3 clk, data held throughout.
   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      bus.data_in = d;
      bus.strobe  = 1'b1;
      wait_clk(3);
      bus.strobe  = 1'b0;
      wait_clk(2);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      state       = S_IDLE;
      bus.strobe  = 1'b0;
      bus.data_in = 8'h00;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(1);
   endtask

   task automatic build_exp(input logic [7:0] key);
      for (int i = 0; i < PIX_BYTES; i++) exp_pix[i*8 +: 8] = 8'(i) ^ key;
      for (int i = 0; i < WT_BYTES; i++)  exp_wt[i*8 +: 8]  = 8'(PIX_BYTES + i) ^ key;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (bus.byte_cnt !== 7'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
      n_total++; if (bus.pixels !== '0) $display("FAIL reset_pixels: got %h expected 0", bus.pixels); else n_pass++;
      n_total++; if (bus.weights !== '0) $display("FAIL reset_weights: got %h expected 0", bus.weights); else n_pass++;
   endtask

   task automatic test_latency();
      do_reset();
      state = S_LOAD;
      @(negedge clk);
      bus.data_in = 8'hA5;
      bus.strobe  = 1'b1;
      @(negedge clk);
      n_total++; if (bus.byte_cnt !== 7'd0) $display("FAIL lat_t1_cnt: got %0d expected 0", bus.byte_cnt); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.byte_cnt !== 7'd0) $display("FAIL lat_t2_cnt: got %0d expected 0", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels[7:0] !== 8'h00) $display("FAIL lat_t2_pix: got %h expected 00", bus.pixels[7:0]); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.byte_cnt !== 7'd1) $display("FAIL lat_t3_cnt: got %0d expected 1", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels[7:0] !== 8'hA5) $display("FAIL lat_t3_pix: got %h expected a5", bus.pixels[7:0]); else n_pass++;
      bus.strobe = 1'b0;
      wait_clk(3);
   endtask

   task automatic test_idle_discard();
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(8'h33);
      n_total++; if (bus.byte_cnt !== 7'd0) $display("FAIL idle_cnt: got %0d expected 0", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels !== '0) $display("FAIL idle_pixels: got %h expected 0", bus.pixels); else n_pass++;
      @(negedge clk);
      bus.data_in = 8'h77;
      bus.strobe  = 1'b1;
      wait_clk(4);
      state = S_LOAD;
      wait_clk(4);
      n_total++; if (bus.byte_cnt !== 7'd0) $display("FAIL held_strobe_cnt: got %0d expected 0", bus.byte_cnt); else n_pass++;
      bus.strobe = 1'b0;
      wait_clk(3);
      send_byte(8'h5C);
      n_total++; if (bus.byte_cnt !== 7'd1) $display("FAIL next_rise_cnt: got %0d expected 1", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels[7:0] !== 8'h5C) $display("FAIL next_rise_pix: got %h expected 5c", bus.pixels[7:0]); else n_pass++;
   endtask

   task automatic test_full_load();
      do_reset();
      build_exp(8'h00);
      state = S_LOAD;
      for (int i = 0; i < LOAD_BYTES; i++) begin
         if (i == LOAD_BYTES - 1) begin
            n_total++; if (bus.byte_cnt !== 7'd106) $display("FAIL pre_last_cnt: got %0d expected 106", bus.byte_cnt); else n_pass++;
            n_total++; if (bus.done !== 1'b0) $display("FAIL pre_last_done: got %b expected 0", bus.done); else n_pass++;
         end
         send_byte(8'(i));
      end
      n_total++; if (bus.pixels[7:0] !== 8'h00) $display("FAIL full_pix_lo: got %h expected 00", bus.pixels[7:0]); else n_pass++;
      n_total++; if (bus.pixels[783:776] !== 8'h61) $display("FAIL full_pix_hi: got %h expected 61", bus.pixels[783:776]); else n_pass++;
      n_total++; if (bus.weights[7:0] !== 8'h62) $display("FAIL full_wt_lo: got %h expected 62", bus.weights[7:0]); else n_pass++;
      n_total++; if (bus.weights[71:64] !== 8'h6A) $display("FAIL full_wt_hi: got %h expected 6a", bus.weights[71:64]); else n_pass++;
      n_total++; if (bus.done !== 1'b1) $display("FAIL full_done: got %b expected 1", bus.done); else n_pass++;
      n_total++; if (bus.byte_cnt !== 7'd107) $display("FAIL full_cnt: got %0d expected 107", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels !== exp_pix) $display("FAIL full_pixels: got %h expected %h", bus.pixels, exp_pix); else n_pass++;
      n_total++; if (bus.weights !== exp_wt) $display("FAIL full_weights: got %h expected %h", bus.weights, exp_wt); else n_pass++;
   endtask

   task automatic test_after_done();
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      n_total++; if (bus.pixels !== exp_pix) $display("FAIL post_done_pixels: got %h expected %h", bus.pixels, exp_pix); else n_pass++;
      n_total++; if (bus.weights !== exp_wt) $display("FAIL post_done_weights: got %h expected %h", bus.weights, exp_wt); else n_pass++;
      n_total++; if (bus.byte_cnt !== 7'd107) $display("FAIL post_done_cnt: got %0d expected 107", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.done !== 1'b1) $display("FAIL post_done_done: got %b expected 1", bus.done); else n_pass++;
   endtask

   task automatic test_resume();
      do_reset();
      build_exp(8'h00);
      state = S_LOAD;
      for (int i = 0; i < 50; i++) send_byte(8'(i));
      n_total++; if (bus.byte_cnt !== 7'd50) $display("FAIL pause_cnt: got %0d expected 50", bus.byte_cnt); else n_pass++;
      state = S_LAYER_1;
      for (int i = 0; i < 3; i++) send_byte(8'hEE);
      wait_clk(2);
      n_total++; if (bus.byte_cnt !== 7'd50) $display("FAIL away_cnt: got %0d expected 50", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels[407:400] !== 8'h00) $display("FAIL away_byte50: got %h expected 00", bus.pixels[407:400]); else n_pass++;
      state = S_LOAD;
      for (int i = 50; i < LOAD_BYTES; i++) send_byte(8'(i));
      n_total++; if (bus.byte_cnt !== 7'd107) $display("FAIL resume_cnt: got %0d expected 107", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.done !== 1'b1) $display("FAIL resume_done: got %b expected 1", bus.done); else n_pass++;
      n_total++; if (bus.pixels[407:400] !== 8'h32) $display("FAIL resume_byte50: got %h expected 32", bus.pixels[407:400]); else n_pass++;
      n_total++; if (bus.pixels !== exp_pix) $display("FAIL resume_pixels: got %h expected %h", bus.pixels, exp_pix); else n_pass++;
      n_total++; if (bus.weights !== exp_wt) $display("FAIL resume_weights: got %h expected %h", bus.weights, exp_wt); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      build_exp(8'h5A);
      state = S_LOAD;
      for (int i = 0; i < 60; i++) send_byte(8'(i) ^ 8'h5A);
      n_total++; if (bus.byte_cnt !== 7'd60) $display("FAIL pre_rst_cnt: got %0d expected 60", bus.byte_cnt); else n_pass++;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (bus.byte_cnt !== 7'd0) $display("FAIL async_rst_cnt: got %0d expected 0", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.pixels !== '0) $display("FAIL async_rst_pixels: got %h expected 0", bus.pixels); else n_pass++;
      n_total++; if (bus.done !== 1'b0) $display("FAIL async_rst_done: got %b expected 0", bus.done); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < LOAD_BYTES; i++) send_byte(8'(i) ^ 8'h5A);
      n_total++; if (bus.byte_cnt !== 7'd107) $display("FAIL reload_cnt: got %0d expected 107", bus.byte_cnt); else n_pass++;
      n_total++; if (bus.done !== 1'b1) $display("FAIL reload_done: got %b expected 1", bus.done); else n_pass++;
      n_total++; if (bus.pixels !== exp_pix) $display("FAIL reload_pixels: got %h expected %h", bus.pixels, exp_pix); else n_pass++;
      n_total++; if (bus.weights !== exp_wt) $display("FAIL reload_weights: got %h expected %h", bus.weights, exp_wt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_idle_discard();
      test_full_load();
      test_after_done();
      test_resume();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_input_loader
`default_nettype wire
